round_robin_distributor: RTL

- Dispatches one valid/ready input stream across SIZE output channels in rotating order. This is the 1-to-N counterpart of the round-robin arbiter's N-to-1 merge.
- Each output channel has a one-entry register slice, so outputs are registered.
- Dispatch is work-conserving: a channel that cannot accept is skipped, not waited on.
- Intended uses: fan-out to parallel worker units, load-balancing across identical pipelines.

---
 rtl/round_robin_distributor.sv | 110 +++++++++++
 1 files changed

// File: rtl/round_robin_distributor.sv
// round_robin_distributor: spreads one valid/ready stream across SIZE output
// channels in rotating order. Each channel owns a one-entry register slice.
// Channels that cannot accept are skipped, so dispatch never waits on a busy
// channel while another one is free.

// One output slice: a single payload register with its full flag.
module rrd_slice #(
    parameter int WIDTH = 8
) (
    input  logic             clock,
    input  logic             resetn,
    input  logic             load,
    input  logic [WIDTH-1:0] load_data,
    input  logic             ready,
    output logic             full,
    output logic [WIDTH-1:0] data
);

    // A load wins over a drain, so a slice emptying this cycle can be
    // refilled in the same cycle and the channel keeps full throughput.
    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) begin
            full <= 1'b0;
            data <= '0;
        end else if (load) begin
            full <= 1'b1;
            data <= load_data;
        end else if (ready) begin
            full <= 1'b0;
        end
    end

endmodule

module round_robin_distributor #(
    parameter int SIZE  = 4,
    parameter int WIDTH = 8
) (
    input  logic                    clock,
    input  logic                    resetn,
    input  logic                    in_valid,
    output logic                    in_ready,
    input  logic [WIDTH-1:0]        in_data,
    output logic [SIZE-1:0]         out_valid,
    input  logic [SIZE-1:0]         out_ready,
    output logic [SIZE*WIDTH-1:0]   out_data,
    output logic [$clog2(SIZE)-1:0] out_channel
);

    localparam int PW = $clog2(SIZE);

    logic [PW-1:0]   pointer;
    logic [PW-1:0]   sel;
    logic [SIZE-1:0] full;
    logic [SIZE-1:0] avail;
    logic [SIZE-1:0] load;
    logic            xfer;

    // A slice can take a payload if it is empty or is being drained now.
    assign avail       = ~full | out_ready;
    assign in_ready    = |avail;
    assign xfer        = in_valid & in_ready;
    assign out_channel = sel;
    assign out_valid   = full;

    // Circular first-available search starting at the pointer. The index is
    // wrapped by subtraction so non-power-of-two SIZE never goes out of range.
    always_comb begin
        int idx;
        logic found;
        sel   = '0;
        found = 1'b0;
        idx   = 0;
        for (int k = 0; k < SIZE; k++) begin
            idx = int'(pointer) + k;
            if (idx >= SIZE) idx = idx - SIZE;
            if (!found && avail[idx]) begin
                found = 1'b1;
                sel   = PW'(idx);
            end
        end
    end

    // Pointer moves just past the channel that took the payload; a stalled
    // or idle input leaves it where it is.
    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) begin
            pointer <= '0;
        end else if (xfer) begin
            pointer <= (sel == PW'(SIZE - 1)) ? '0 : sel + PW'(1);
        end
    end

    generate
        for (genvar i = 0; i < SIZE; i++) begin : g_slice
            assign load[i] = xfer && (sel == PW'(i));

            rrd_slice #(.WIDTH(WIDTH)) u_slice (
                .clock     (clock),
                .resetn    (resetn),
                .load      (load[i]),
                .load_data (in_data),
                .ready     (out_ready[i]),
                .full      (full[i]),
                .data      (out_data[i*WIDTH +: WIDTH])
            );
        end
    endgenerate

endmodule
